// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine for short PHY SIG/service fields.
// Consumes BPC message bits per clock and pulses valid with the finalised CRC.
module crc_serial_engine #(
  parameter int unsigned      CRC_W       = 8,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0] INIT        = '1,
  parameter logic [CRC_W-1:0] XOR_OUT     = '1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter int unsigned      MAX_LEN     = 34,
  parameter int unsigned      BPC         = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic                           abort,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len,
  input  logic [MAX_LEN-1:0]             d,
  output logic                           busy,
  output logic                           valid,
  output logic [CRC_W-1:0]               crc
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   c_q, c_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [MAX_LEN-1:0] d_q, d_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               valid_q, valid_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [CRC_W-1:0]   c_step;
  logic [CRC_W-1:0]   c_rev;
  logic [CRC_W-1:0]   c_fin;
  logic [MAX_LEN-1:0] d_sh;

  always_comb begin
    len_clamped = len;
    if (32'(len) > MAX_LEN) len_clamped = LEN_W'(MAX_LEN);
  end

  // Up to BPC sequential bit updates; bits beyond the remaining count are skipped.
  always_comb begin
    c_step = c_q;
    d_sh   = d_q;
    for (int unsigned k = 0; k < BPC; k++) begin
      if (k < 32'(rem_q)) begin
        if (c_step[CRC_W-1] ^ d_sh[0]) c_step = (c_step << 1) ^ POLY;
        else                           c_step = c_step << 1;
      end
      d_sh = d_sh >> 1;
    end
  end

  always_comb begin
    c_rev = {<<{c_q}};
    c_fin = XOR_OUT ^ (REFLECT_OUT ? c_rev : c_q);
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    crc_d   = crc_q;
    d_d     = d_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else if (start) begin
      d_d     = d;
      rem_d   = len_clamped;
      c_d     = INIT;
      crc_d   = '0;
      state_d = (len_clamped == '0) ? StDone : StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          c_d = c_step;
          d_d = d_q >> BPC;
          if (32'(rem_q) <= BPC) begin
            rem_d   = '0;
            state_d = StDone;
          end else begin
            rem_d = rem_q - LEN_W'(BPC);
          end
        end
        StDone: begin
          crc_d   = c_fin;
          valid_d = 1'b1;
          state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      c_q     <= '0;
      crc_q   <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      crc_q   <= crc_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = valid_q;
  assign crc   = crc_q;

endmodule
